// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit holding HI/LO.
// Ports: clk, reset (async, active-low), Start, MDOp[2:0], A, B -> Busy, HI, LO.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [2:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;

  logic        launch;
  logic        is_mult;
  logic [63:0] prod_s;
  logic [63:0] prod_u;

  logic        div_sgn;
  logic        neg_a;
  logic        neg_b;
  logic        div_zero;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] safe_b;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  assign launch  = Start && (MDOp >= OP_MULT)
                && (MDOp <= OP_DIVU);
  assign is_mult = (MDOp == OP_MULT)
                || (MDOp == OP_MULTU);

  // Low 64 bits of a 64x64 product of the
  // sign-extended operands equal the signed product.
  assign prod_s = {{32{a_q[31]}}, a_q}
                * {{32{b_q[31]}}, b_q};
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  // Signed divide on magnitudes; the most negative
  // dividend keeps its bit pattern as an unsigned magnitude.
  assign div_sgn  = (op_q == OP_DIV);
  assign neg_a    = div_sgn & a_q[31];
  assign neg_b    = div_sgn & b_q[31];
  assign mag_a    = neg_a ? (~a_q + 32'd1) : a_q;
  assign mag_b    = neg_b ? (~b_q + 32'd1) : b_q;
  assign div_zero = (b_q == 32'd0);
  assign safe_b   = div_zero ? 32'd1 : mag_b;
  assign q_mag    = mag_a / safe_b;
  assign r_mag    = mag_a % safe_b;
  assign quot     = (neg_a ^ neg_b) ? (~q_mag + 32'd1) : q_mag;
  assign rem      = neg_a ? (~r_mag + 32'd1) : r_mag;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      Busy  <= 1'b0;
      cnt   <= 4'd0;
      op_q  <= 3'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      HI    <= 32'd0;
      LO    <= 32'd0;
    end else begin
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            launch: begin
              state <= RUN;
              Busy  <= 1'b1;
              op_q  <= MDOp;
              a_q   <= A;
              b_q   <= B;
              cnt   <= is_mult ? MULT_N : DIV_N;
            end
            (MDOp == OP_MTHI): HI <= A;
            (MDOp == OP_MTLO): LO <= A;
            default: ;
          endcase
        end
        RUN: begin
          if (cnt == 4'd1) begin
            state <= IDLE;
            Busy  <= 1'b0;
            cnt   <= 4'd0;
            case (op_q)
              OP_MULT: begin
                HI <= prod_s[63:32];
                LO <= prod_s[31:0];
              end
              OP_MULTU: begin
                HI <= prod_u[63:32];
                LO <= prod_u[31:0];
              end
              OP_DIV, OP_DIVU: begin
                if (!div_zero) begin
                  HI <= rem;
                  LO <= quot;
                end
              end
              default: ;
            endcase
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit in the E stage, holding the architectural HI/LO registers.
- Executes mult, multu, div, divu, mthi and mtlo.
- Produces the Busy indication consumed by the hazard stall logic. While Busy or Start is high, the stall logic freezes any D-stage mult/div/mfhi/mflo/mthi/mtlo.

Parameters:
- MULT_CYCLES, 5: number of Busy cycles for mult/multu (1..15).
- DIV_CYCLES, 10: number of Busy cycles for div/divu (1..15).

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-low reset.
- Start, input, 1: one-cycle pulse from E stage; qualifies MDOp as a mult/div launch.
- MDOp, input, 3: operation code. 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- A, input, 32: rs operand (forwarded value).
- B, input, 32: rt operand (forwarded value).
- Busy, output, 1: operation in progress.
- HI, output, 32: HI register.
- LO, output, 32: LO register.

Behaviour:
- Reset (reset=0, asynchronous, dominates): Busy=0, HI=0, LO=0, state IDLE, counter=0, operand latches=0. Reset asserted mid-operation aborts the operation; HI/LO stay 0 after release.
- States:
  - IDLE: Busy=0.
  - RUN: Busy=1; 4-bit down-counter plus latched op, A and B.
- IDLE -> RUN: on a clk edge with Start=1 and MDOp in {1..4}. Latch op, A and B; load counter with MULT_CYCLES or DIV_CYCLES. Busy=1 from that edge.
- RUN: counter decrements each edge. On the edge where counter==1:
  - go to IDLE, Busy=0;
  - HI/LO take the result computed from the latched operands, on that same edge.
  - Busy is high for exactly N cycles. New HI/LO are visible the same cycle Busy falls.
- Operand latching: A and B may change after the launch edge without affecting the result.
- Results:
  - mult: signed 32x32 -> 64; HI = upper 32 bits, LO = lower 32 bits.
  - multu: as mult, unsigned.
  - div: signed; LO = quotient truncated toward zero, HI = remainder with the sign of the dividend. 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - divu: unsigned; LO = quotient, HI = remainder.
- Divide by zero (B==0 for div/divu): full DIV_CYCLES Busy period still runs; HI and LO are unchanged at completion.
- mthi/mtlo (MDOp 5/6, Start ignored) in IDLE: HI or LO <= A on the next edge; Busy stays 0; no latency beyond one edge.
- Start or mthi/mtlo while in RUN: ignored. The stall logic guarantees this does not occur; the unit must not corrupt state if it does.
- MDOp 1..4 with Start=0: no action.
- Start=1 with MDOp 0, 5, 6 or 7: no launch. For 5/6 the mthi/mtlo rule applies.
- HI/LO change only on:
  - mthi/mtlo edges;
  - the completion edge of a non-zero-divisor operation;
  - reset.

Test Plan:
- Reset: drive reset=0 mid-run of a div (cycle 4 of 10), release -> Busy=0, HI=0, LO=0 immediately; nothing updates later.
- mult: A=0xFFFFFFFF, B=0x00000002, Start at edge 0; change A/B to 0 at edge 1 -> Busy=1 for edges 0..4, Busy=0 after edge 5, HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- multu: same operands -> HI=0x00000001, LO=0xFFFFFFFE after 5 Busy cycles.
- div and divu:
  - div A=0xFFFFFFF9 (-7), B=2 -> after 10 Busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu A=7, B=2 -> LO=3, HI=1.
- Divide by zero: after mthi A=0x1234 and mtlo A=0x5678 (one edge each, Busy stays 0), divu A=7, B=0 -> Busy high 10 cycles, then HI=0x1234, LO=0x5678.
- Start while busy: during a mult, assert Start with div and mthi for one cycle at cycle 2 -> ignored; completion still at cycle 5 with the mult result; Busy falls at cycle 5.
